// File: rtl/shift_add_mult4_pkg.sv
// +-----------------------------------------------------------------------+
// | shift_add_mult4_pkg                                                   |
// | Shared widths, RUN length and state encoding for the 4x4 multiplier.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package shift_add_mult4_pkg;

  localparam int C_OP_W       = 4;
  localparam int C_PROD_W     = 8;
  localparam int C_RUN_CYCLES = 4;
  localparam int C_CNT_W      = $clog2(C_RUN_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/adder4_core.sv
// +-----------------------------------------------------------------------+
// | adder4_core                                                           |
// | 4-bit ripple-carry adder with carry-out and signed overflow flag.     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module adder4_core
  import shift_add_mult4_pkg::*;
(
  input  logic [C_OP_W-1:0] x,
  input  logic [C_OP_W-1:0] y,
  input  logic              c0,
  output logic [C_OP_W-1:0] s,
  output logic              c4,
  output logic              v
);

  logic [C_OP_W:0] w_c;

  assign w_c[0] = c0;

  generate
    for (genvar gi = 0; gi < C_OP_W; gi++) begin : g_ripple
      assign s[gi]     = x[gi] ^ y[gi] ^ w_c[gi];
      assign w_c[gi+1] = (x[gi] & y[gi]) | (w_c[gi] & (x[gi] ^ y[gi]));
    end
  endgenerate

  assign c4 = w_c[C_OP_W];
  // Overflow is meaningful only for two's-complement operands.
  assign v  = w_c[C_OP_W] ^ w_c[C_OP_W-1];

endmodule

`default_nettype wire

// File: rtl/shift_add_mult4.sv
// +-----------------------------------------------------------------------+
// | shift_add_mult4                                                       |
// | Sequential unsigned 4x4 shift-and-add multiplier, 4 RUN cycles.       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module shift_add_mult4
  import shift_add_mult4_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [C_OP_W-1:0]   a,
  input  logic [C_OP_W-1:0]   b,
  output logic                busy,
  output logic                done,
  output logic [C_PROD_W-1:0] product
);

  state_t               r_state;
  state_t               w_state_next;
  logic [C_OP_W-1:0]    r_mcand;
  logic [C_OP_W-1:0]    r_q;
  logic [C_OP_W-1:0]    r_acc;
  logic [C_CNT_W-1:0]   r_cnt;
  logic [C_PROD_W-1:0]  r_product;

  logic [C_OP_W-1:0]    w_addend;
  logic [C_OP_W-1:0]    w_sum;
  logic                 w_c4;
  logic                 w_unused_v;
  logic                 w_last_run;

  assign w_addend   = r_q[0] ? r_mcand : '0;
  assign w_last_run = (r_cnt == C_CNT_W'(C_RUN_CYCLES - 1));

  adder4_core u_adder (
    .x  (r_acc),
    .y  (w_addend),
    .c0 (1'b0),
    .s  (w_sum),
    .c4 (w_c4),
    .v  (w_unused_v)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_RUN;
      ST_RUN:  if (w_last_run) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand   <= '0;
      r_q       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mcand <= a;
            r_q     <= b;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          // {c4,sum,q} shifted right by one: sum LSB moves into q.
          r_acc <= {w_c4, w_sum[C_OP_W-1:1]};
          r_q   <= {w_sum[0], r_q[C_OP_W-1:1]};
          r_cnt <= r_cnt + C_CNT_W'(1);
          if (w_last_run) begin
            r_product <= {w_c4, w_sum, r_q[C_OP_W-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);
  assign product = r_product;

endmodule

`default_nettype wire
